// File: rtl/debouncer_bank.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | debouncer_bank: multi-channel debouncer for L-active inputs, falling edge |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module debouncer_bank #(
   parameter int CHANNELS      = 8,
   parameter int STABLE_CYCLES = 4,
   parameter int CNT_W         = 3,
   parameter int SYNC_STAGES   = 2,
   parameter bit RELEASE_FAST  = 1'b0
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                sample_en,
   input  logic [CHANNELS-1:0] in,
   output logic [CHANNELS-1:0] out,
   output logic [CHANNELS-1:0] assert_pulse,
   output logic [CHANNELS-1:0] release_pulse,
   output logic                any_event      // "event" is a reserved word
);

   localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(STABLE_CYCLES - 1);

   generate
      if ((STABLE_CYCLES < 1) || (STABLE_CYCLES > (1 << CNT_W) - 1)) begin : g_bad_stable
         $error("debouncer_bank: STABLE_CYCLES out of range for CNT_W");
      end
      if ((SYNC_STAGES < 2) || (SYNC_STAGES > 3)) begin : g_bad_sync
         $error("debouncer_bank: SYNC_STAGES must be 2 or 3");
      end
   endgenerate

   logic [SYNC_STAGES-1:0] r_sync [CHANNELS];
   logic [CNT_W-1:0]       r_cnt  [CHANNELS];

   logic [CNT_W-1:0]       w_cnt_nxt [CHANNELS];
   logic [CHANNELS-1:0]    w_s;
   logic [CHANNELS-1:0]    w_out_nxt;
   logic [CHANNELS-1:0]    w_ast;
   logic [CHANNELS-1:0]    w_rel;

   always_comb begin
      w_s       = '0;
      w_out_nxt = out;
      w_ast     = '0;
      w_rel     = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         w_cnt_nxt[i] = r_cnt[i];
         w_s[i]       = r_sync[i][SYNC_STAGES-1];
         if (w_s[i] == out[i]) begin
            // any return to the current level restarts qualification
            w_cnt_nxt[i] = '0;
         end else if (RELEASE_FAST && !out[i]) begin
            w_out_nxt[i] = 1'b1;
            w_cnt_nxt[i] = '0;
            w_rel[i]     = 1'b1;
         end else if (sample_en) begin
            if (r_cnt[i] == c_cnt_last) begin
               w_out_nxt[i] = w_s[i];
               w_cnt_nxt[i] = '0;
               w_ast[i]     = ~w_s[i];
               w_rel[i]     = w_s[i];
            end else begin
               w_cnt_nxt[i] = r_cnt[i] + 1'b1;
            end
         end
      end
   end

   always_ff @(negedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < CHANNELS; i++) begin
            r_sync[i] <= '1;
            r_cnt[i]  <= '0;
         end
         out           <= '1;
         assert_pulse  <= '0;
         release_pulse <= '0;
         any_event     <= 1'b0;
      end else begin
         for (int i = 0; i < CHANNELS; i++) begin
            r_sync[i] <= {r_sync[i][SYNC_STAGES-2:0], in[i]};
            r_cnt[i]  <= w_cnt_nxt[i];
         end
         out           <= w_out_nxt;
         assert_pulse  <= w_ast;
         release_pulse <= w_rel;
         any_event     <= |{w_ast, w_rel};
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_debouncer_bank.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_debouncer_bank: scoreboard bench for debouncer_bank (slow/fast release)|
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_debouncer_bank;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       sample_en;
   logic [7:0] in, in_f;
   logic [7:0] out, ap, rp;
   logic [7:0] out_f, ap_f, rp_f;
   logic       ev, ev_f;

   int n_vec = 0;
   int n_bad = 0;
   int edge_n = 0;

   typedef struct {
      int         edge_no;
      logic [7:0] o;
      logic [7:0] ap;
      logic [7:0] rp;
      logic       ev;
   } exp_t;

   exp_t sb_main[$];
   exp_t sb_fast[$];

   logic [7:0] eo, eof;
   int         b, r;

   debouncer_bank #(.RELEASE_FAST(1'b0)) dut (
      .clk(clk), .reset_n(reset_n), .sample_en(sample_en), .in(in),
      .out(out), .assert_pulse(ap), .release_pulse(rp), .any_event(ev)
   );

   debouncer_bank #(.RELEASE_FAST(1'b1)) dut_f (
      .clk(clk), .reset_n(reset_n), .sample_en(sample_en), .in(in_f),
      .out(out_f), .assert_pulse(ap_f), .release_pulse(rp_f), .any_event(ev_f)
   );

   always #5 clk = ~clk;

   always @(negedge clk) edge_n++;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, edge_n);
      end
   endtask

   task automatic expect_range(input bit fast, input int first, input int last,
                               input logic [7:0] o, input logic [7:0] a,
                               input logic [7:0] rl, input logic e);
      exp_t x;
      for (int k = first; k <= last; k++) begin
         x.edge_no = k; x.o = o; x.ap = a; x.rp = rl; x.ev = e;
         if (fast) sb_fast.push_back(x);
         else      sb_main.push_back(x);
      end
   endtask

   task automatic compare(input string pfx, input exp_t x, input logic [7:0] o,
                          input logic [7:0] a, input logic [7:0] rl, input logic e);
      if (x.edge_no < edge_n)
         check_val({pfx, "_late"}, edge_n, x.edge_no);
      else begin
         check_val({pfx, "_out"}, o, x.o);
         check_val({pfx, "_assert"}, a, x.ap);
         check_val({pfx, "_release"}, rl, x.rp);
         check_val({pfx, "_event"}, e, x.ev);
      end
   endtask

   // outputs settle at the falling edge and are sampled on the rising edge
   always @(posedge clk) begin
      while (sb_main.size() > 0 && sb_main[0].edge_no <= edge_n)
         compare("main", sb_main.pop_front(), out, ap, rp, ev);
      while (sb_fast.size() > 0 && sb_fast[0].edge_no <= edge_n)
         compare("fast", sb_fast.pop_front(), out_f, ap_f, rp_f, ev_f);
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset_n = 1'b0; sample_en = 1'b1; in = 8'hFF; in_f = 8'hFF;
      eo = 8'hFF; eof = 8'hFF;
      repeat (3) @(posedge clk);
      #1;
      check_val("rst_out", out, 8'hFF);
      check_val("rst_assert", ap, 8'h00);
      check_val("rst_release", rp, 8'h00);
      check_val("rst_event", ev, 1'b0);
      check_val("rst_out_f", out_f, 8'hFF);
      @(posedge clk); reset_n = 1'b1;
      repeat (3) @(posedge clk);

      // single assertion on channel 0
      @(posedge clk); b = edge_n; in[0] = 1'b0;
      expect_range(0, b+1, b+5, eo, 8'h00, 8'h00, 1'b0);
      eo[0] = 1'b0;
      expect_range(0, b+6, b+6, eo, 8'h01, 8'h00, 1'b1);
      expect_range(0, b+7, b+7, eo, 8'h00, 8'h00, 1'b0);
      repeat (7) @(posedge clk);

      // glitch on channel 3: low 3 edges, high 1 edge, then low
      @(posedge clk); b = edge_n; in[3] = 1'b0;
      expect_range(0, b+1, b+9, eo, 8'h00, 8'h00, 1'b0);
      eo[3] = 1'b0;
      expect_range(0, b+10, b+10, eo, 8'h08, 8'h00, 1'b1);
      expect_range(0, b+11, b+11, eo, 8'h00, 8'h00, 1'b0);
      repeat (3) @(posedge clk); in[3] = 1'b1;
      @(posedge clk); in[3] = 1'b0;
      repeat (7) @(posedge clk);

      // channel 1 assert on both instances, then release slow vs fast
      @(posedge clk); b = edge_n; in[1] = 1'b0; in_f[1] = 1'b0;
      expect_range(0, b+1, b+5, eo, 8'h00, 8'h00, 1'b0);
      expect_range(1, b+1, b+5, eof, 8'h00, 8'h00, 1'b0);
      eo[1] = 1'b0; eof[1] = 1'b0;
      expect_range(0, b+6, b+6, eo, 8'h02, 8'h00, 1'b1);
      expect_range(1, b+6, b+6, eof, 8'h02, 8'h00, 1'b1);
      expect_range(0, b+7, b+7, eo, 8'h00, 8'h00, 1'b0);
      expect_range(1, b+7, b+7, eof, 8'h00, 8'h00, 1'b0);
      repeat (8) @(posedge clk);
      @(posedge clk); b = edge_n; in[1] = 1'b1; in_f[1] = 1'b1;
      expect_range(0, b+1, b+5, eo, 8'h00, 8'h00, 1'b0);
      expect_range(1, b+1, b+2, eof, 8'h00, 8'h00, 1'b0);
      eo[1] = 1'b1; eof[1] = 1'b1;
      expect_range(0, b+6, b+6, eo, 8'h00, 8'h02, 1'b1);
      expect_range(1, b+3, b+3, eof, 8'h00, 8'h02, 1'b1);
      expect_range(0, b+7, b+7, eo, 8'h00, 8'h00, 1'b0);
      expect_range(1, b+4, b+7, eof, 8'h00, 8'h00, 1'b0);
      repeat (8) @(posedge clk);

      // channel 2 with sample_en high on every 4th edge only
      @(posedge clk); b = edge_n; in[2] = 1'b0;
      expect_range(0, b+1, b+15, eo, 8'h00, 8'h00, 1'b0);
      eo[2] = 1'b0;
      expect_range(0, b+16, b+16, eo, 8'h04, 8'h00, 1'b1);
      expect_range(0, b+17, b+17, eo, 8'h00, 8'h00, 1'b0);
      for (int e = 1; e <= 18; e++) begin
         sample_en = ((e % 4) == 0);
         @(posedge clk);
      end
      sample_en = 1'b1;

      // release channel 0, then channels 0 and 7 fall together
      @(posedge clk); b = edge_n; in[0] = 1'b1;
      expect_range(0, b+1, b+5, eo, 8'h00, 8'h00, 1'b0);
      eo[0] = 1'b1;
      expect_range(0, b+6, b+6, eo, 8'h00, 8'h01, 1'b1);
      expect_range(0, b+7, b+7, eo, 8'h00, 8'h00, 1'b0);
      repeat (8) @(posedge clk);
      @(posedge clk); b = edge_n; in[0] = 1'b0; in[7] = 1'b0;
      expect_range(0, b+1, b+5, eo, 8'h00, 8'h00, 1'b0);
      eo[0] = 1'b0; eo[7] = 1'b0;
      expect_range(0, b+6, b+6, eo, 8'h81, 8'h00, 1'b1);
      expect_range(0, b+7, b+8, eo, 8'h00, 8'h00, 1'b0);
      repeat (9) @(posedge clk);

      // reset while channel 5 is mid-qualification (count at 3)
      @(posedge clk); b = edge_n; in[5] = 1'b0;
      expect_range(0, b+1, b+5, eo, 8'h00, 8'h00, 1'b0);
      repeat (5) @(posedge clk);
      #2 reset_n = 1'b0;
      #1;
      check_val("rst2_out", out, 8'hFF);
      check_val("rst2_assert", ap, 8'h00);
      check_val("rst2_release", rp, 8'h00);
      check_val("rst2_event", ev, 1'b0);
      eo = 8'hFF;
      repeat (2) @(posedge clk);
      reset_n = 1'b1; r = edge_n;
      // every input still held low re-qualifies with the full latency
      expect_range(0, r+1, r+5, eo, 8'h00, 8'h00, 1'b0);
      expect_range(0, r+6, r+6, in, ~in, 8'h00, 1'b1);
      eo = in;
      expect_range(0, r+7, r+8, eo, 8'h00, 8'h00, 1'b0);
      repeat (10) @(posedge clk);

      #1;
      check_val("sb_main_drained", sb_main.size(), 0);
      check_val("sb_fast_drained", sb_fast.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
